instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the immediate generator and decode logic. It owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake. It presents each fetched instruction with its PC to decode over a valid/ready handshake. Taken-branch redirects are computed from the sign-extended B-type immediate that the immediate generator sends back.

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, masters imem req/gnt/rvalid, feeds decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_imm,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
`ifdef FETCH_MISALIGN_CHECK_EN
    FAULT,
`endif
    DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] sum;
  logic [31:0] tgt;

  assign pc_inc = pc + 32'd4;
  assign sum    = branch_pc + branch_imm;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis;
  assign tgt = sum;
  assign mis = |sum[1:0];
`else
  assign tgt = {sum[31:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (branch_taken && mis && state != FAULT) begin
        state       <= FAULT;
        pc          <= tgt;
        imem_req    <= 1'b0;
        instr_valid <= 1'b0;
        fetch_fault <= 1'b1;
      end else
`endif
      begin
        case (state)
          REQ: begin
            if (branch_taken) begin
              pc        <= tgt;
              imem_req  <= 1'b0;
              imem_addr <= tgt;
              if (imem_req && imem_gnt)
                state <= DISCARD;
            end else if (imem_req && imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          WAIT: begin
            if (branch_taken) begin
              pc <= tgt;
              if (imem_rvalid) begin
                imem_req  <= 1'b1;
                imem_addr <= tgt;
                state     <= REQ;
              end else begin
                state <= DISCARD;
              end
            end else if (imem_rvalid) begin
              instr_out   <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (branch_taken) begin
              pc          <= tgt;
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              imem_addr   <= tgt;
              state       <= REQ;
            end else if (instr_ready) begin
              pc          <= pc_inc;
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              imem_addr   <= pc_inc;
              state       <= REQ;
            end
          end
          DISCARD: begin
            if (branch_taken)
              pc <= tgt;
            // the stale response must still retire, even alongside a redirect
            if (imem_rvalid) begin
              imem_req  <= 1'b1;
              imem_addr <= branch_taken ? tgt : pc;
              state     <= REQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, pc/instr scoreboard,
// redirect vector table and multi-cycle corner sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = 32'h0;
  logic [31:0] branch_imm = 32'h0;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_imm(branch_imm), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bpc;
    logic [31:0] bimm;
    bit          rdy;
    logic [31:0] tgt;
  } vec_t;

  vec_t        vecs[6];
  int          total = 0;
  int          bad = 0;
  int          cycles = 0;
  int          proto = 0;
  int          deadbeef = 0;
  logic [31:0] expq[$];
  int          rises[$];
  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  int          pend_wait = 0;
  int          lat = 1;
  bit          rd_force = 0;
  logic [31:0] rd_val = 0;
  bit          prev_req = 0;
  bit          prev_gnt = 0;
  logic [31:0] prev_addr = 0;
  bit          prev_valid = 0;

  function automatic logic [31:0] memf(logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic xfer(logic [31:0] p, logic [31:0] i);
    logic [31:0] e;
    if (i == 32'hDEAD_BEEF) deadbeef++;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL xfer_unexpected: got pc %h want none", p);
      return;
    end
    e = expq.pop_front();
    chk("xfer_pc", p, e);
    chk("xfer_instr", i, memf(e));
  endtask

  task automatic cyc();
    bit g;
    bit xf;
    logic [31:0] xp;
    logic [31:0] xi;
    g = imem_req && !pend;
    imem_gnt = g;
    imem_rvalid = pend && pend_wait == 0;
    imem_rdata = imem_rvalid ? (rd_force ? rd_val : memf(pend_addr)) : 32'h0;
    if (imem_req && pend) proto++;
    if (prev_req && !prev_gnt && imem_req && imem_addr != prev_addr) proto++;
    prev_req = imem_req;
    prev_gnt = g;
    prev_addr = imem_addr;
    xf = instr_valid && instr_ready && !branch_taken;
    xp = pc_out;
    xi = instr_out;
    @(posedge clk);
    #1;
    cycles++;
    if (imem_rvalid) pend = 0;
    else if (pend) pend_wait--;
    if (g) begin
      pend = 1;
      pend_addr = prev_addr;
      pend_wait = lat - 1;
    end
    if (instr_valid && !prev_valid) rises.push_back(cycles);
    prev_valid = instr_valid;
    if (xf) xfer(xp, xi);
  endtask

  task automatic wait_valid(string nm);
    int n = 0;
    while (!instr_valid && n < 50) begin
      cyc();
      n++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL %s: instr_valid got 0 want 1 (timeout)", nm);
    end
  endtask

  task automatic wait_req(string nm);
    int n = 0;
    while (!imem_req && n < 50) begin
      cyc();
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL %s: imem_req got 0 want 1 (timeout)", nm);
    end
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hp;
    logic [31:0] hi;
    int moved;
    int reqs;
    vecs[0] = '{32'h0000_0200, 32'hFFFF_FFF0, 1'b0, 32'h0000_01F0};
    vecs[1] = '{32'h0000_1000, 32'h0000_0008, 1'b1, 32'h0000_1008};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'h0000_0123, 32'h0000_0001, 1'b0, 32'h0000_0124};
    vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0004, 1'b1, 32'h8000_0000};
    vecs[5] = '{32'hFFFF_FFF0, 32'h0000_000C, 1'b0, 32'hFFFF_FFFC};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_fault", fetch_fault, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cycles = 0;
    rises.delete();

    instr_ready = 1'b1;
    expq.push_back(32'h100);
    expq.push_back(32'h104);
    expq.push_back(32'h108);
    cyc();
    chk("req_first_edge", imem_req, 1);
    chk("req_first_addr", imem_addr, 32'h100);
    repeat (9) cyc();
    instr_ready = 1'b0;
    chk("stream_drained", expq.size(), 0);
    if (rises.size() < 3) begin
      total++;
      bad++;
      $display("FAIL stream_pulses: got %0d want 3", rises.size());
    end else begin
      chk("stream_first", rises[0], 3);
      chk("stream_gap1", rises[1] - rises[0], 3);
      chk("stream_gap2", rises[2] - rises[1], 3);
    end

    wait_valid("hold_fill");
    chk("hold_pc", pc_out, 32'h10C);
    hp = pc_out;
    hi = instr_out;
    moved = 0;
    reqs = 0;
    repeat (5) begin
      cyc();
      if (pc_out !== hp || instr_out !== hi || !instr_valid) moved++;
      if (imem_req) reqs++;
    end
    chk("hold_stable", moved, 0);
    chk("hold_no_req", reqs, 0);
    expq.push_back(32'h10C);
    accept();
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h110);

    foreach (vecs[k]) begin
      wait_valid("vec_fill");
      branch_pc = vecs[k].bpc;
      branch_imm = vecs[k].bimm;
      branch_taken = 1'b1;
      instr_ready = vecs[k].rdy;
      cyc();
      branch_taken = 1'b0;
      instr_ready = 1'b0;
      chk("vec_valid_drop", instr_valid, 0);
      wait_req("vec_req");
      chk("vec_target", imem_addr, vecs[k].tgt);
      expq.push_back(vecs[k].tgt);
      wait_valid("vec_fetch");
      accept();
      chk("vec_next", imem_addr, vecs[k].tgt + 32'd4);
    end

    lat = 3;
    cyc();
    branch_pc = 32'h200;
    branch_imm = 32'hFFFF_FFF0;
    branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    chk("wait_redir_noreq", imem_req, 0);
    wait_req("wait_redir_req");
    chk("wait_redir_addr", imem_addr, 32'h1F0);
    expq.push_back(32'h1F0);
    wait_valid("wait_redir_fetch");
    accept();

    lat = 1;
    cyc();
    branch_pc = 32'h300;
    branch_imm = 32'h40;
    branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    chk("wait_rv_redir_req", imem_req, 1);
    chk("wait_rv_redir_addr", imem_addr, 32'h340);
    chk("wait_rv_redir_valid", instr_valid, 0);
    expq.push_back(32'h340);
    wait_valid("wait_rv_fetch");
    accept();

    deadbeef = 0;
    rd_force = 1;
    rd_val = 32'hDEAD_BEEF;
    branch_pc = 32'h400;
    branch_imm = 32'h20;
    branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    chk("gnt_redir_noreq", imem_req, 0);
    wait_req("gnt_redir_req");
    rd_force = 0;
    chk("gnt_redir_addr", imem_addr, 32'h420);
    expq.push_back(32'h420);
    wait_valid("gnt_redir_fetch");
    chk("gnt_redir_pc", pc_out, 32'h420);
    accept();
    chk("deadbeef_seen", deadbeef, 0);

    lat = 3;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_valid", instr_valid, 0);
    pend = 0;
    cyc();
    rst_n = 1'b1;
    lat = 1;
    cyc();
    chk("midrst_addr", imem_addr, 32'h100);
    expq.push_back(32'h100);
    wait_valid("midrst_fetch");
    accept();

    wait_valid("mis_fill");
    branch_pc = 32'h0;
    branch_imm = 32'h6;
    branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", fetch_fault, 1);
    reqs = 0;
    repeat (5) begin
      cyc();
      if (imem_req || instr_valid) reqs++;
    end
    chk("mis_quiet", reqs, 0);
    chk("mis_fault_held", fetch_fault, 1);
`else
    chk("mis_nofault", fetch_fault, 0);
    wait_req("mis_req");
    chk("mis_aligned_addr", imem_addr, 32'h4);
    expq.push_back(32'h4);
    wait_valid("mis_fetch");
    accept();
`endif

    chk("scoreboard_empty", expq.size(), 0);
    chk("protocol", proto, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
